// File: rtl/keys_pkg.sv
// rtl/keys_pkg.sv - shared register map and bus width for the keys reader
package keys_pkg;

  localparam int DATA_W = 8;

  localparam logic [3:0] ADDR_STATE = 4'd0;
  localparam logic [3:0] ADDR_EDGE  = 4'd1;
  localparam logic [3:0] ADDR_MASK  = 4'd2;
  localparam logic [3:0] ADDR_RAW   = 4'd3;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one-bit synchroniser, polarity fix, debounce counter and rise pulse
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic raw,
  output logic deb,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          level;
  logic          meta;
  logic          deb_prev;
  logic [CW-1:0] cnt;

  // Inverting ahead of the first flop lets every flop reset to "not pressed".
  assign level = ACTIVE_LOW ? ~pin : pin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= 1'b0;
      raw      <= 1'b0;
      deb      <= 1'b0;
      deb_prev <= 1'b0;
      cnt      <= '0;
    end else begin
      meta     <= level;
      raw      <= meta;
      deb_prev <= deb;
      if (raw == deb) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        deb <= raw;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign rise = deb & ~deb_prev;

endmodule

// File: rtl/keys_reader.sv
// rtl/keys_reader.sv - Avalon-MM slave exposing debounced keys, edge capture and interrupt
module keys_reader
  import keys_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic              csi_clk,
  input  logic              csi_reset_n,
  input  logic [3:0]        avs_s1_address,
  input  logic              avs_s1_read,
  output logic [DATA_W-1:0] avs_s1_readdata,
  input  logic              avs_s1_write,
  input  logic [DATA_W-1:0] avs_s1_writedata,
  output logic              ins_irq0_irq,
  input  logic [WIDTH-1:0]  coe_keys
);

  localparam logic [DATA_W-1:0] LANE_MASK = DATA_W'((1 << WIDTH) - 1);

  logic [WIDTH-1:0]  raw;
  logic [WIDTH-1:0]  deb;
  logic [WIDTH-1:0]  rise;
  logic [DATA_W-1:0] edge_q;
  logic [DATA_W-1:0] mask_q;
  logic [DATA_W-1:0] clr;
  logic              wr_edge;
  logic              wr_mask;

  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_deb (
      .clk  (csi_clk),
      .rst_n(csi_reset_n),
      .pin  (coe_keys[i]),
      .raw  (raw[i]),
      .deb  (deb[i]),
      .rise (rise[i])
    );
  end

  assign wr_edge = avs_s1_write && (avs_s1_address == ADDR_EDGE);
  assign wr_mask = avs_s1_write && (avs_s1_address == ADDR_MASK);
  assign clr     = wr_edge ? (avs_s1_writedata & LANE_MASK) : '0;

  // OR-ing the rise in after the clear makes a capture win over a same-cycle W1C.
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      edge_q <= '0;
      mask_q <= '0;
    end else begin
      edge_q <= (edge_q & ~clr) | DATA_W'(rise);
      if (wr_mask) mask_q <= avs_s1_writedata & LANE_MASK;
    end
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      avs_s1_readdata <= '0;
    end else if (avs_s1_read) begin
      case (avs_s1_address)
        ADDR_STATE: avs_s1_readdata <= DATA_W'(deb);
        ADDR_EDGE:  avs_s1_readdata <= edge_q;
        ADDR_MASK:  avs_s1_readdata <= mask_q;
        ADDR_RAW:   avs_s1_readdata <= DATA_W'(raw);
        default:    avs_s1_readdata <= '0;
      endcase
    end
  end

  assign ins_irq0_irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_keys_reader.sv
// tb/tb_keys_reader.sv - directed self-checking bench for keys_reader
module tb_keys_reader;

  localparam int WIDTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] address;
  logic       read;
  logic [7:0] readdata;
  logic       write;
  logic [7:0] writedata;
  logic       irq;
  logic [3:0] keys;

  int n_cmp = 0;
  int n_bad = 0;

  keys_reader #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .csi_clk         (clk),
    .csi_reset_n     (rst_n),
    .avs_s1_address  (address),
    .avs_s1_read     (read),
    .avs_s1_readdata (readdata),
    .avs_s1_write    (write),
    .avs_s1_writedata(writedata),
    .ins_irq0_irq    (irq),
    .coe_keys        (keys)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    address = a;
    read    = 1'b1;
    @(posedge clk);
    #1;
    read = 1'b0;
    d    = readdata;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(posedge clk);
    #1;
    write = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int idx;
    int cnt;

    rst_n = 1'b0; address = '0; read = 1'b0; write = 1'b0; writedata = '0; keys = 4'hF;
    #1;
    check_eq("reset_readdata", readdata, 8'h00);
    check_eq("reset_irq", {7'd0, irq}, 8'h00);
    idle(3);
    rst_n = 1'b1;
    idle(2);

    rd(4'd0, d); check_eq("idle_state", d, 8'h00);
    rd(4'd1, d); check_eq("idle_edge", d, 8'h00);
    rd(4'd2, d); check_eq("idle_mask", d, 8'h00);
    rd(4'd3, d); check_eq("idle_raw", d, 8'h00);
    rd(4'd7, d); check_eq("idle_addr7", d, 8'h00);
    idle(6);
    rd(4'd0, d); check_eq("idle_state_late", d, 8'h00);

    // Press key 0: RAW must appear within 3 clocks, STATE exactly 4 clocks later.
    keys = 4'hE;
    idx = 99;
    for (int i = 1; i <= 20; i++) begin
      rd(4'd3, d);
      if (d[0]) begin idx = i; break; end
    end
    check_eq("raw_latency_ok", {7'd0, idx <= 4}, 8'h01);
    check_eq("raw_value", d, 8'h01);
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      rd(4'd0, d);
      cnt++;
      if (d != 8'h00) break;
    end
    check_eq("state_delay", 8'(cnt), 8'd4);
    check_eq("state_key0", d, 8'h01);
    rd(4'd1, d); check_eq("edge_key0", d, 8'h01);
    check_eq("irq_unmasked", {7'd0, irq}, 8'h00);

    // Bounce key 1: 3 clocks pressed, 1 released, five times.
    for (int r = 0; r < 5; r++) begin
      keys = 4'hC; idle(3);
      keys = 4'hE; idle(1);
    end
    idle(8);
    rd(4'd0, d); check_eq("bounce_state", d, 8'h01);
    rd(4'd1, d); check_eq("bounce_edge", d, 8'h01);

    // Read and write MASK together: old value returned, upper bits dropped.
    address = 4'd2; writedata = 8'hF1; read = 1'b1; write = 1'b1;
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    check_eq("rw_same_cycle", readdata, 8'h00);
    check_eq("irq_masked_on", {7'd0, irq}, 8'h01);
    rd(4'd2, d); check_eq("mask_upper_dropped", d, 8'h01);
    wr(4'd7, 8'hFF);
    rd(4'd7, d); check_eq("addr7_write_ignored", d, 8'h00);
    rd(4'd2, d); check_eq("mask_after_addr7", d, 8'h01);
    wr(4'd1, 8'h01);
    check_eq("irq_after_w1c", {7'd0, irq}, 8'h00);
    keys = 4'hF;
    idle(10);
    rd(4'd0, d); check_eq("release_state", d, 8'h00);
    rd(4'd1, d); check_eq("release_edge", d, 8'h00);
    check_eq("release_irq", {7'd0, irq}, 8'h00);

    // Key 2: W1C lands on the same edge the capture sets EDGE[2].
    keys = 4'hB;
    idle(6);
    wr(4'd1, 8'h04);
    rd(4'd1, d); check_eq("set_beats_clear", d, 8'h04);
    wr(4'd2, 8'h04);
    check_eq("irq_key2", {7'd0, irq}, 8'h01);

    // Reset with key 3 partway through its debounce count.
    keys = 4'h3;
    idle(4);
    rst_n = 1'b0;
    #1;
    check_eq("midreset_irq", {7'd0, irq}, 8'h00);
    check_eq("midreset_readdata", readdata, 8'h00);
    idle(2);
    rst_n = 1'b1;
    idx = 99;
    for (int i = 1; i <= 20; i++) begin
      rd(4'd0, d);
      if (d != 8'h00) begin idx = i; break; end
    end
    check_eq("requalify_delay", 8'(idx), 8'd7);
    check_eq("requalify_state", d, 8'h0C);
    rd(4'd1, d); check_eq("requalify_edge", d, 8'h0C);
    rd(4'd2, d); check_eq("requalify_mask", d, 8'h00);
    check_eq("requalify_irq", {7'd0, irq}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
